// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounced key press / auto-repeat event source for the matrix CPU core.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   tick               sample strobe; debounce and repeat counting advance only when high
//   keys_n             raw active-low buttons (asynchronous)
//   di                 interrupt disable; blocks launching of new events
//   key_state          debounced levels, 1 = pressed
//   evt_valid/evt_ack  event handshake; evt_code, evt_repeat, evt_vector held while valid
//   overrun            sticky, a press was lost
// Build option: define KEY_REPEAT_EN to include the auto-repeat counter and owner logic.
module key_event_ctrl #(
    parameter int NKEYS        = 6,
    parameter int DEB_TICKS    = 16,
    parameter int REPEAT_DELAY = 200,
    parameter int REPEAT_RATE  = 50,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [NKEYS-1:0] keys_n,
    input  logic             di,
    output logic [NKEYS-1:0] key_state,
    output logic             evt_valid,
    output logic [2:0]       evt_code,
    output logic             evt_repeat,
    output logic [7:0]       evt_vector,
    input  logic             evt_ack,
    output logic             overrun
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t state_q, state_d;
    logic [NKEYS-1:0] s1_q, s1_d, s2_q, s2_d, stable_q, stable_d;
    logic [NKEYS-1:0] pending_q, pending_d, is_press_q, is_press_d;
    logic [NKEYS-1:0] press, fire_vec, clr;
    logic [CNT_W-1:0] cnt_q [NKEYS];
    logic [CNT_W-1:0] cnt_d [NKEYS];
    logic             overrun_q, overrun_d, rep_q, rep_d;
    logic [2:0]       code_q, code_d, sel;
    logic [7:0]       vec_q, vec_d;

`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
    logic [2:0]       own_q, own_d;
    logic             own_v_q, own_v_d, rphase_q, rphase_d, fire;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;

    // Owner is taken from the stable value being loaded so the delay is measured from the accepted press.
    always_comb begin
        own_d    = '0;
        own_v_d  = 1'b0;
        rcnt_d   = '0;
        rphase_d = 1'b0;
        fire     = 1'b0;
        for (int k = NKEYS - 1; k >= 0; k--)
            if (stable_d[k]) begin
                own_d   = 3'(k);
                own_v_d = 1'b1;
            end
        if (own_v_d && own_v_q && own_d == own_q) begin
            rcnt_d   = rcnt_q;
            rphase_d = rphase_q;
            if (tick) begin
                if (rcnt_q + 1'b1 == (rphase_q ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY))) begin
                    fire     = 1'b1;
                    rcnt_d   = '0;
                    rphase_d = 1'b1;
                end else
                    rcnt_d = rcnt_q + 1'b1;
            end
        end
        fire_vec = fire ? NKEYS'(1) << own_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own_q    <= '0;
            own_v_q  <= 1'b0;
            rcnt_q   <= '0;
            rphase_q <= 1'b0;
        end else begin
            own_q    <= own_d;
            own_v_q  <= own_v_d;
            rcnt_q   <= rcnt_d;
            rphase_q <= rphase_d;
        end
    end
`else
    localparam bit REP_EN = 1'b0;
    logic unused_rep;
    assign unused_rep = |{REPEAT_DELAY, REPEAT_RATE};
    assign fire_vec   = '0;
`endif

    always_comb begin
        s1_d     = ~keys_n;
        s2_d     = s1_q;
        stable_d = stable_q;
        for (int k = 0; k < NKEYS; k++) begin
            cnt_d[k] = '0;
            if (s2_q[k] != stable_q[k]) begin
                if (tick && cnt_q[k] == CNT_W'(DEB_TICKS - 1))
                    stable_d[k] = ~stable_q[k];
                else
                    cnt_d[k] = tick ? cnt_q[k] + 1'b1 : cnt_q[k];
            end
        end
        press = stable_d & ~stable_q;
    end

    always_comb begin
        sel     = '0;
        clr     = '0;
        state_d = state_q;
        code_d  = code_q;
        rep_d   = rep_q;
        vec_d   = vec_q;
        for (int k = NKEYS - 1; k >= 0; k--)
            if (pending_q[k]) sel = 3'(k);
        if (state_q == IDLE) begin
            if (!di && |pending_q) begin
                state_d  = PRESENT;
                code_d   = sel;
                rep_d    = REP_EN & ~is_press_q[sel];
                vec_d    = 8'd2 + {4'd0, sel, 1'b0};
                clr[sel] = 1'b1;
            end
        end else if (evt_ack)
            state_d = IDLE;
        // New sets win over the presenter's clear, so a fresh press during delivery becomes a later event.
        pending_d  = (pending_q & ~clr) | press | fire_vec;
        is_press_d = (is_press_q & ~clr) | press;
        overrun_d  = overrun_q | (|(press & pending_q & is_press_q & ~clr));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            stable_q   <= '0;
            pending_q  <= '0;
            is_press_q <= '0;
            overrun_q  <= 1'b0;
            code_q     <= '0;
            rep_q      <= 1'b0;
            vec_q      <= '0;
            for (int k = 0; k < NKEYS; k++) cnt_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            is_press_q <= is_press_d;
            overrun_q  <= overrun_d;
            code_q     <= code_d;
            rep_q      <= rep_d;
            vec_q      <= vec_d;
            for (int k = 0; k < NKEYS; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign key_state  = stable_q;
    assign evt_valid  = state_q == PRESENT;
    assign evt_code   = code_q;
    assign evt_repeat = rep_q;
    assign evt_vector = vec_q;
    assign overrun    = overrun_q;
endmodule
